ram_dp_clr: RTL



---
 rtl/ram_pkg.sv | 20 ++
 rtl/ram_dp_clr_if.sv | 36 +++
 rtl/ram_dp_core.sv | 53 +++++
 rtl/ram_dp_clr.sv | 94 +++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ============================================================================
// Module      : ram_pkg
// Description : State encoding and default geometry shared by the memory blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_pkg;

    localparam int c_ADDR_W = 11;
    localparam int c_DATA_W = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/ram_dp_clr_if.sv
// ============================================================================
// Module      : ram_dp_clr_if
// Description : Bus bundle for ram_dp_clr: CPU port A, video port B, clear control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram_dp_clr_if
    import ram_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W
);

    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_wren;
    logic [DATA_W-1:0] a_q;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_q;
    logic              clr_req;
    logic              busy;

    modport master (
        output a_addr, a_data, a_wren, b_addr, clr_req,
        input  a_q, b_q, busy
    );

    modport slave (
        input  a_addr, a_data, a_wren, b_addr, clr_req,
        output a_q, b_q, busy
    );

endinterface

`default_nettype wire

// File: rtl/ram_dp_core.sv
// ============================================================================
// Module      : ram_dp_core
// Description : Inferable dual-port array; A read/write with write-through,
//               B read-only with read-before-write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_dp_core #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input  wire logic              clock,
    input  wire logic              reset_n,
    input  wire logic [ADDR_W-1:0] a_addr_i,
    input  wire logic [DATA_W-1:0] a_data_i,
    input  wire logic              a_wren_i,
    output logic      [DATA_W-1:0] a_q_o,
    input  wire logic [ADDR_W-1:0] b_addr_i,
    input  wire logic              b_ovr_i,
    input  wire logic [DATA_W-1:0] b_ovr_data_i,
    output logic      [DATA_W-1:0] b_q_o
);

    localparam int c_DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [c_DEPTH];
    logic [DATA_W-1:0] a_rd_q;
    logic [DATA_W-1:0] b_rd_q;

    // The array itself carries no reset so it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (a_wren_i) begin
            mem_q[a_addr_i] <= a_data_i;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_rd_q <= '0;
            b_rd_q <= '0;
        end else begin
            a_rd_q <= a_wren_i ? a_data_i : mem_q[a_addr_i];
            b_rd_q <= b_ovr_i ? b_ovr_data_i : mem_q[b_addr_i];
        end
    end

    assign a_q_o = a_rd_q;
    assign b_q_o = b_rd_q;

endmodule

`default_nettype wire

// File: rtl/ram_dp_clr.sv
// ============================================================================
// Module      : ram_dp_clr
// Description : Dual-port RAM with clear sequencer; sweep built only when
//               RAM_DP_CLR_CLEAR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_dp_clr
    import ram_pkg::*;
#(
    parameter int                 ADDR_W = c_ADDR_W,
    parameter int                 DATA_W = c_DATA_W,
    parameter logic [DATA_W-1:0]  FILL   = '0
) (
    input  wire logic  clock,
    input  wire logic  reset_n,
    ram_dp_clr_if.slave bus
);

    logic              w_busy;
    logic [ADDR_W-1:0] w_a_addr;
    logic [DATA_W-1:0] w_a_data;
    logic              w_a_wren;

`ifdef RAM_DP_CLR_CLEAR_EN
    localparam logic [ADDR_W-1:0] c_CNT_LAST = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter wraps to zero on the terminal write, so no explicit reload.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.clr_req) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == c_CNT_LAST) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    assign w_busy   = (state_q == ST_CLEAR);
    assign w_a_addr = w_busy ? cnt_q : bus.a_addr;
    assign w_a_data = w_busy ? FILL  : bus.a_data;
    assign w_a_wren = w_busy | bus.a_wren;
`else
    wire w_unused_clr_req = bus.clr_req;

    assign w_busy   = 1'b0;
    assign w_a_addr = bus.a_addr;
    assign w_a_data = bus.a_data;
    assign w_a_wren = bus.a_wren;
`endif

    ram_dp_core #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_core (
        .clock        (clock),
        .reset_n      (reset_n),
        .a_addr_i     (w_a_addr),
        .a_data_i     (w_a_data),
        .a_wren_i     (w_a_wren),
        .a_q_o        (bus.a_q),
        .b_addr_i     (bus.b_addr),
        .b_ovr_i      (w_busy),
        .b_ovr_data_i (FILL),
        .b_q_o        (bus.b_q)
    );

    assign bus.busy = w_busy;

endmodule

`default_nettype wire
